uart_sync_fifo: RTL
===================

Name: uart_sync_fifo

Overview:
- Synthesizable, parametrised synchronous FIFO for the UART TX/RX data paths.
- Supports any depth, including non-power-of-2.
- Provides registered status: empty, full, almost-empty, almost-full and an occupancy count.
- Sticky overflow/underflow error flags let the CSR block report misuse without stalling the datapath.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; legal range ≥ 2; any integer.
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL.
- Legality: 0 ≤ AE_LEVEL < AF_LEVEL ≤ DEPTH; elaboration-time check, fatal on violation.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- push  in  1  write request
- write_data  in  WIDTH  data written on an accepted push
- pop  in  1  read request; consumes the entry currently on read_data
- read_data  out  WIDTH  head-of-queue data, registered
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AE_LEVEL
- almost_full  out  1  count ≥ AF_LEVEL
- count  out  CW  occupancy, where CW = $clog2(DEPTH+1)
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a pop was issued while empty
- clr_err  in  1  clears overflow, underflow (and peak, if enabled)

Behaviour:
- Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, read_data=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Storage array is not reset. rst overrides every other input, including mid-burst; all queued data is discarded.
- All outputs are registered and reflect the state after the current edge's operations. No extra cycle of lag.
- Show-ahead (FWFT) read: when !empty, read_data holds the oldest entry. pop at an edge makes the next entry visible after that edge.
- Push into an empty FIFO: data appears on read_data and empty deasserts after the same edge (1-cycle write-to-read latency).
- read_data when empty: holds its last value; it never goes X.
- Accepted push: push & (!full | pop). Data is written at wr_ptr and wr_ptr advances.
- Accepted pop: pop & !empty. rd_ptr advances.
- Push & pop while full: both are accepted; count stays DEPTH; no overflow.
- Push & pop while empty: the push is accepted, the pop is ignored, underflow is set, and count becomes 1.
- Push while full without pop: data is dropped, overflow is set, and state is unchanged.
- Pop while empty: ignored; underflow is set.
- count_next = count + accepted_push − accepted_pop. It never leaves the range 0..DEPTH.
- Pointer wrap: DEPTH-1 → 0 by explicit compare, never by bit truncation (supports non-power-of-2 DEPTH).
- Sticky flags: set on the event; cleared by clr_err. If clr_err coincides with a new error event in the same cycle, set wins.

Optional Feature:
- Macro: UART_SYNC_FIFO_PEAK_EN.
- Defined: adds output port peak [CW-1:0], the high-water mark.
  - Register update: peak <= max(peak, count_next).
  - Reset value 0.
  - clr_err reloads peak with count_next.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package uart_fifo_pkg holds:
  - function fifo_cnt_w(depth) returning $clog2(depth+1);
  - typedef fifo_status_t, a packed struct {empty, full, almost_empty, almost_full, overflow, underflow} for CSR consumption;
  - localparam defaults UART_FIFO_DEPTH=16, UART_FIFO_WIDTH=8.
- Sub-module uart_fifo_ptr: a wrap-around pointer with ports clk, rst, inc, ptr and parameter DEPTH. Instantiated twice (write and read pointers).

Test Plan (DEPTH=5, WIDTH=8, AF_LEVEL=4, AE_LEVEL=1):
- Fill/drain: push 0x11..0x15 on 5 consecutive cycles.
  - After each edge: count=1..5; almost_empty drops at count=2; almost_full rises at count=4; full at count=5.
  - Pop 5 times: read_data sequence 0x11..0x15; empty=1 after the last pop.
- Overflow: with the FIFO full, push 0xAA with no pop → count stays 5, overflow=1, 0xAA is never read.
  - Pulse clr_err → overflow=0.
- Full pass-through: with the FIFO full, push 0x66 & pop in the same cycle → count=5, overflow=0, head advances.
  - 0x66 is read 5th in the following drain.
- Underflow / empty corner:
  - Pop with the FIFO empty → underflow=1, count=0, read_data unchanged.
  - Push 0x77 & pop together while empty → count=1, read_data=0x77, underflow=1.
- Wrap-around: 12 cycles of interleaved push/pop across the non-power-of-2 boundary → data order is preserved and count matches a scoreboard every cycle.
- Reset mid-operation: with count=3, assert rst for 1 cycle → all outputs at their reset values (read_data=0, empty=1).
  - Then push 0x42 → read_data=0x42 next cycle; with UART_SYNC_FIFO_PEAK_EN, peak=1.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared types and helpers for the UART data-path FIFO.
// Holds the default geometry, the count-width helper and the packed
// status word that the CSR block consumes.
package uart_fifo_pkg;

    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_FIFO_WIDTH = 8;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Status bits in the order the CSR block expects them.
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/uart_fifo_ptr.sv
// Wrap-around pointer for the UART FIFO storage array.
// Wraps from DEPTH-1 back to 0 by explicit compare, so any DEPTH works,
// not only powers of two.
module uart_fifo_ptr #(
    parameter int DEPTH = 16,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Advance on inc, wrapping at the last slot; reset returns to slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO for the UART TX/RX data paths.
// Any DEPTH >= 2 (non-power-of-2 included). All outputs are registered and
// reflect the state after the current edge; read_data holds the oldest entry
// whenever the FIFO is not empty and keeps its last value when it is.
// Optional build macro UART_SYNC_FIFO_PEAK_EN adds a high-water-mark port.
module uart_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH    = UART_FIFO_WIDTH,
    parameter int DEPTH    = UART_FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             write_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             read_data,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_empty,
    output logic                         almost_full,
    output logic [fifo_cnt_w(DEPTH)-1:0] count,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clr_err
`ifdef UART_SYNC_FIFO_PEAK_EN
    ,
    output logic [fifo_cnt_w(DEPTH)-1:0] peak
`endif
);

    localparam int CW = fifo_cnt_w(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

    // An empty FIFO always satisfies almost_empty and never almost_full,
    // because 0 <= AE_LEVEL < AF_LEVEL.
    localparam fifo_status_t RESET_STATUS = '{
        empty:        1'b1,
        full:         1'b0,
        almost_empty: 1'b1,
        almost_full:  1'b0,
        overflow:     1'b0,
        underflow:    1'b0
    };

    // Refuse to elaborate with an inconsistent geometry.
    generate
        if (DEPTH < 2 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
            $fatal(1, "uart_sync_fifo: need DEPTH>=2 and 0<=AE_LEVEL<AF_LEVEL<=DEPTH");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_nxt;

    logic             push_acc;
    logic             pop_acc;

    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] read_data_q;
    logic [WIDTH-1:0] read_data_d;
    fifo_status_t     status_q;
    fifo_status_t     status_d;

    uart_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_acc),
        .ptr (wr_ptr)
    );

    uart_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_acc),
        .ptr (rd_ptr)
    );

    // Decide which requests are accepted and where the queue head lands.
    always_comb begin
        // A full FIFO still accepts a push when a pop frees a slot on the same edge.
        push_acc   = push & (~status_q.full | pop);
        pop_acc    = pop & ~status_q.empty;
        count_d    = count_q + CW'(push_acc) - CW'(pop_acc);
        rd_ptr_nxt = rd_ptr;
        if (pop_acc) begin
            rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        end
    end

    // Next head-of-queue value; when the only remaining entry is the one
    // being written this edge, bypass the array and take write_data.
    always_comb begin
        read_data_d = read_data_q;
        if (count_d != '0) begin
            if (push_acc && (count_q == CW'(pop_acc))) begin
                read_data_d = write_data;
            end else begin
                read_data_d = mem[rd_ptr_nxt];
            end
        end
    end

    // Status flags derived from the post-edge occupancy; error flags are
    // sticky and a new error in the same cycle as clr_err keeps the flag set.
    always_comb begin
        status_d              = status_q;
        status_d.empty        = (count_d == '0);
        status_d.full         = (count_d == DEPTH_CNT);
        status_d.almost_empty = (count_d <= AE_CNT);
        status_d.almost_full  = (count_d >= AF_CNT);
        status_d.overflow     = (push & status_q.full & ~pop) | (status_q.overflow  & ~clr_err);
        status_d.underflow    = (pop & status_q.empty)        | (status_q.underflow & ~clr_err);
    end

    // Storage write; the array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= write_data;
        end
    end

    // Registered occupancy, head data and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            read_data_q <= '0;
            status_q    <= RESET_STATUS;
        end else begin
            count_q     <= count_d;
            read_data_q <= read_data_d;
            status_q    <= status_d;
        end
    end

    assign read_data    = read_data_q;
    assign count        = count_q;
    assign empty        = status_q.empty;
    assign full         = status_q.full;
    assign almost_empty = status_q.almost_empty;
    assign almost_full  = status_q.almost_full;
    assign overflow     = status_q.overflow;
    assign underflow    = status_q.underflow;

`ifdef UART_SYNC_FIFO_PEAK_EN
    logic [CW-1:0] peak_q;
    logic [CW-1:0] peak_d;

    // High-water mark; clr_err restarts tracking from the current occupancy.
    always_comb begin
        peak_d = peak_q;
        if (clr_err) begin
            peak_d = count_d;
        end else if (count_d > peak_q) begin
            peak_d = count_d;
        end
    end

    // Peak register.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`endif

endmodule
